// File: rtl/tuple_reg_arbiter_if.sv
// Request bus for tuple_reg_arbiter: two requesters, each with
// valid/sel/value/lock driven by the master and ready returned by the arbiter.
interface tuple_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_sel;
    logic [WIDTH-1:0] req0_value;
    logic             req0_lock;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_sel;
    logic [WIDTH-1:0] req1_value;
    logic             req1_lock;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_sel, req0_value, req0_lock,
        output req1_valid, req1_sel, req1_value, req1_lock,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_sel, req0_value, req0_lock,
        input  req1_valid, req1_sel, req1_value, req1_lock,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/tuple_reg_arbiter.sv
// Two-requester arbiter guarding a register tuple (a0, a1) with optional
// exclusive locking. Ports: CLK, RESET (sync, active-high), bus (slave
// modport: per-requester valid/sel/value/lock in, ready out), O_a0/O_a1
// (registered fields), owner (one-hot lock holder), wr_count (accepted
// writes, wraps). Define TUPLE_ARB_ROUND_ROBIN_EN to break IDLE ties
// against the last granted requester; otherwise requester 0 wins ties.
module tuple_reg_arbiter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] INIT_A0 = '0,
    parameter logic [WIDTH-1:0] INIT_A1 = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    tuple_reg_arbiter_if.slave bus,
    output logic [WIDTH-1:0] O_a0,
    output logic [WIDTH-1:0] O_a1,
    output logic [1:0]       owner,
    output logic [7:0]       wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a0_q, a0_d;
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [1:0]       owner_q, owner_d;
    logic [7:0]       wr_count_q, wr_count_d;
    // 1 = requester 1 was granted last; reset value makes 0 win first tie
    logic             last_q, last_d;

    logic rdy0, rdy1;
    logic tie_to1;
    logic xfer0, xfer1;

    always_comb begin
`ifdef TUPLE_ARB_ROUND_ROBIN_EN
        tie_to1 = ~last_q;
`else
        tie_to1 = 1'b0;
`endif
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (!RESET) begin
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        rdy0 = ~tie_to1;
                        rdy1 = tie_to1;
                    end else begin
                        rdy0 = bus.req0_valid;
                        rdy1 = bus.req1_valid;
                    end
                end
                LOCK0:   rdy0 = 1'b1;
                LOCK1:   rdy1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;

    assign xfer0 = bus.req0_valid & rdy0;
    assign xfer1 = bus.req1_valid & rdy1;

    always_comb begin
        state_d    = state_q;
        a0_d       = a0_q;
        a1_d       = a1_q;
        wr_count_d = wr_count_q;
        last_d     = last_q;
        if (xfer0) begin
            if (bus.req0_sel) a0_d = bus.req0_value;
            else              a1_d = bus.req0_value;
            wr_count_d = wr_count_q + 8'd1;
            last_d     = 1'b0;
            state_d    = bus.req0_lock ? LOCK0 : IDLE;
        end else if (xfer1) begin
            if (bus.req1_sel) a0_d = bus.req1_value;
            else              a1_d = bus.req1_value;
            wr_count_d = wr_count_q + 8'd1;
            last_d     = 1'b1;
            state_d    = bus.req1_lock ? LOCK1 : IDLE;
        end else begin
            // holder idle: keep lock only while it still asks for it
            case (state_q)
                LOCK0:   if (!bus.req0_lock) state_d = IDLE;
                LOCK1:   if (!bus.req1_lock) state_d = IDLE;
                default: ;
            endcase
        end
        case (state_d)
            LOCK0:   owner_d = 2'b01;
            LOCK1:   owner_d = 2'b10;
            default: owner_d = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            a0_q       <= INIT_A0;
            a1_q       <= INIT_A1;
            owner_q    <= 2'b00;
            wr_count_q <= 8'd0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            owner_q    <= owner_d;
            wr_count_q <= wr_count_d;
            last_q     <= last_d;
        end
    end

    assign O_a0     = a0_q;
    assign O_a1     = a1_q;
    assign owner    = owner_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_tuple_reg_arbiter.sv
// Directed self-checking bench for tuple_reg_arbiter.
// Covers reset, single writes, tie arbitration, locking, wrap and reset-in-lock.
module tb_tuple_reg_arbiter;

    logic       CLK;
    logic       RESET;
    logic [7:0] O_a0, O_a1;
    logic [1:0] owner;
    logic [7:0] wr_count;

    int n_chk;
    int n_fail;

    tuple_reg_arbiter_if #(.WIDTH(8)) bus ();

    tuple_reg_arbiter #(
        .WIDTH   (8),
        .INIT_A0 (8'h12),
        .INIT_A1 (8'h34)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus.slave),
        .O_a0     (O_a0),
        .O_a1     (O_a1),
        .owner    (owner),
        .wr_count (wr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic s,
                          input logic [7:0] val, input logic l);
        bus.req0_valid = v;
        bus.req0_sel   = s;
        bus.req0_value = val;
        bus.req0_lock  = l;
    endtask

    task automatic drive1(input logic v, input logic s,
                          input logic [7:0] val, input logic l);
        bus.req1_valid = v;
        bus.req1_sel   = s;
        bus.req1_value = val;
        bus.req1_lock  = l;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic       rr;
    logic       g;
    logic [7:0] e_a0, e_a1;

    initial begin
        n_chk  = 0;
        n_fail = 0;
`ifdef TUPLE_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        // reset with both requesters valid: no ready, INIT values
        @(negedge CLK);
        RESET = 1'b1;
        drive0(1'b1, 1'b1, 8'hEE, 1'b0);
        drive1(1'b1, 1'b0, 8'hDD, 1'b0);
        #1;
        check("rst_rdy0", bus.req0_ready, 0);
        check("rst_rdy1", bus.req1_ready, 0);
        tick();
        tick();
        check("rst_a0", O_a0, 8'h12);
        check("rst_a1", O_a1, 8'h34);
        check("rst_cnt", wr_count, 0);
        check("rst_own", owner, 0);

        // single write from requester 0
        @(negedge CLK);
        RESET = 1'b0;
        drive0(1'b1, 1'b1, 8'hAB, 1'b0);
        drive1(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("w0_rdy0", bus.req0_ready, 1);
        check("w0_rdy1", bus.req1_ready, 0);
        tick();
        check("w0_a0", O_a0, 8'hAB);
        check("w0_a1", O_a1, 8'h34);
        check("w0_cnt", wr_count, 1);

        // restore pointer, then 4 cycles of ties
        @(negedge CLK);
        RESET = 1'b1;
        drive0(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        e_a0 = 8'h12;
        e_a1 = 8'h34;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            RESET = 1'b0;
            drive0(1'b1, 1'b1, 8'h10 + 8'(i), 1'b0);
            drive1(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
            g = rr & i[0];
            #1;
            check("tie_rdy0", bus.req0_ready, {31'd0, ~g});
            check("tie_rdy1", bus.req1_ready, {31'd0, g});
            if (g) e_a1 = 8'h20 + 8'(i);
            else   e_a0 = 8'h10 + 8'(i);
            tick();
        end
        check("tie_a0", O_a0, e_a0);
        check("tie_a1", O_a1, e_a1);
        check("tie_cnt", wr_count, 4);

        // requester 1 locks, requester 0 starved meanwhile
        @(negedge CLK);
        drive0(1'b0, 1'b0, 8'h00, 1'b0);
        drive1(1'b1, 1'b0, 8'h55, 1'b1);
        #1;
        check("lk_rdy1", bus.req1_ready, 1);
        tick();
        check("lk_own", owner, 2'b10);
        check("lk_a1", O_a1, 8'h55);
        check("lk_cnt", wr_count, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive0(1'b1, 1'b1, 8'h99, 1'b0);
            drive1(1'b0, 1'b0, 8'h00, 1'b1);
            #1;
            check("hold_rdy0", bus.req0_ready, 0);
            check("hold_rdy1", bus.req1_ready, 1);
            tick();
            check("hold_own", owner, 2'b10);
            check("hold_cnt", wr_count, 5);
        end
        @(negedge CLK);
        drive1(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("rel_rdy0", bus.req0_ready, 0);
        tick();
        check("rel_own", owner, 0);
        check("rel_a0", O_a0, e_a0);
        @(negedge CLK);
        drive0(1'b1, 1'b1, 8'h66, 1'b0);
        #1;
        check("post_rdy0", bus.req0_ready, 1);
        tick();
        check("post_a0", O_a0, 8'h66);
        check("post_cnt", wr_count, 6);

        // 250 more writes: 6 + 250 = 256 -> wraps to 0
        for (int k = 0; k < 250; k++) begin
            @(negedge CLK);
            drive0(1'b1, 1'b1, 8'(k), 1'b0);
            tick();
            if (k == 248) check("cnt_255", wr_count, 255);
        end
        check("cnt_wrap", wr_count, 0);
        check("wrap_a0", O_a0, 8'd249);

        // enter LOCK0, then reset on a transfer cycle
        @(negedge CLK);
        drive0(1'b1, 1'b1, 8'h77, 1'b1);
        tick();
        check("l0_own", owner, 2'b01);
        check("l0_a0", O_a0, 8'h77);
        @(negedge CLK);
        RESET = 1'b1;
        drive0(1'b1, 1'b0, 8'h99, 1'b1);
        #1;
        check("rl_rdy0", bus.req0_ready, 0);
        tick();
        check("rl_own", owner, 0);
        check("rl_a0", O_a0, 8'h12);
        check("rl_a1", O_a1, 8'h34);
        check("rl_cnt", wr_count, 0);

        // first cycle after reset acts as IDLE; tie goes to 0
        @(negedge CLK);
        RESET = 1'b0;
        drive0(1'b1, 1'b1, 8'h42, 1'b0);
        drive1(1'b1, 1'b1, 8'h43, 1'b0);
        #1;
        check("pr_rdy0", bus.req0_ready, 1);
        check("pr_rdy1", bus.req1_ready, 0);
        tick();
        check("pr_a0", O_a0, 8'h42);
        check("pr_cnt", wr_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tuple_reg_arbiter.md
TUPLE_REG_ARBITER -- requirements
Module: tuple_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of each tuple field a0, a1 and of each request value.
REQ-002 Parameter INIT_A0, default 0: reset value of field a0.
REQ-003 Parameter INIT_A1, default 0: reset value of field a1.
REQ-004 Port CLK  input  1  rising-edge clock; one clock for the block.
REQ-005 Port RESET  input  1  reset, synchronous and active-high.
REQ-006 Port req0_valid / req1_valid  input  1  requester n presents a write.
REQ-007 Port req0_sel / req1_sel  input  1  field select: 1 writes a0, 0 writes a1.
REQ-008 Port req0_value / req1_value  input  WIDTH  write data.
REQ-009 Port req0_lock / req1_lock  input  1  requester n asks to keep exclusive ownership after this write.
REQ-010 Port req0_ready / req1_ready  output  1  combinational; a write transfers on a cycle where valid and ready are both 1.
REQ-011 Port O_a0 / O_a1  output  WIDTH  registered tuple fields.
REQ-012 Port owner  output  2  one-hot lock holder; 00 when unlocked.
REQ-013 Port wr_count  output  8  registered count of accepted writes; wraps 255 -> 0.

Function
REQ-014 FSM states: IDLE, LOCK0, LOCK1; at most one ready asserted per cycle.
REQ-015 In IDLE, a sole valid requester gets ready=1; with no valid, both readies are 0.
REQ-016 In IDLE with both valid, arbitration follows REQ-030/REQ-031.
REQ-017 In LOCKn, req_n_ready=1 and the other requester's ready=0 regardless of its valid.
REQ-018 Accepted write: sel=1 -> a0<=value, a1 held; sel=0 -> a1<=value, a0 held; visible on O_* one cycle after the transfer.
REQ-019 Accepted write from n with lock=1: next state LOCKn; with lock=0: next state IDLE.
REQ-020 In LOCKn with req_n_lock=0 and valid=0: return to IDLE next cycle, no write.
REQ-021 In LOCKn with req_n_lock=1 and valid=0: stay in LOCKn, no write.
REQ-022 owner = 01 in LOCK0, 10 in LOCK1, 00 in IDLE; registered, tracks state.
REQ-023 wr_count increments by 1 per accepted transfer, including wrap from 255 to 0.
REQ-024 last-grant pointer updates to n on every accepted transfer from n.
REQ-025 Field registers change only on accepted transfers or reset.

Reset
REQ-026 RESET=1 at a rising CLK edge: state<=IDLE, a0<=INIT_A0, a1<=INIT_A1, wr_count<=0, owner<=00, last-grant pointer<=1.
REQ-027 While RESET=1, both readies SHALL be 0 and no transfer is accepted.
REQ-028 RESET asserted in LOCKn or on a transfer cycle: reset wins; the write is discarded and the lock is released.
REQ-029 The first cycle after RESET deasserts behaves as IDLE.

Configuration
REQ-030 With macro TUPLE_ARB_ROUND_ROBIN_EN defined: simultaneous valids in IDLE grant the requester not equal to the last-grant pointer, so requester 0 wins the first tie after reset.
REQ-031 Without TUPLE_ARB_ROUND_ROBIN_EN: simultaneous valids in IDLE always grant requester 0; the pointer is still maintained but unused.

Verification
REQ-032 Reset with INIT_A0=0x12, INIT_A1=0x34 -> O_a0=0x12, O_a1=0x34, wr_count=0, owner=00, both ready=0 during reset.
REQ-033 req0 valid, sel=1, value=0xAB, lock=0 -> req0_ready=1; next cycle O_a0=0xAB, O_a1 unchanged, wr_count=1.
REQ-034 Both valid for 4 cycles, lock=0 -> with TUPLE_ARB_ROUND_ROBIN_EN grants are 0,1,0,1; without it grants are 0,0,0,0.
REQ-035 req1 writes with lock=1 and holds lock for 3 cycles while req0 is valid -> owner=10, req0_ready=0 throughout; req1 drops lock with valid=0 -> IDLE next cycle, req0 granted the following cycle.
REQ-036 256 accepted writes -> wr_count wraps to 0; RESET pulsed in LOCK0 during a transfer -> write discarded, owner=00, fields at INIT values.
